weighted_rr_arbiter: RTL
========================

// Module: weighted_rr_arbiter
// PURPOSE
//  Registered N-port round-robin arbiter with per-port burst weights, grant lock and a
//  valid/ready grant handshake. Successor to the combinational port selector used in
//  ProcessorControl. Sits between requesting units and a shared resource (memory port,
//  writeback bus). Holds a grant for up to WEIGHT transfers and handles non-power-of-two
//  PORTCOUNT exactly, with no index correction.
// PARAMETERS
//  PORTCOUNT      4   number of requesting ports (>=2, need not be a power of two)
//  PORTADDRWIDTH  2   width of GrantIndex; must equal $clog2(PORTCOUNT)
//  WEIGHTWIDTH    4   width of each per-port weight field
//  ROUNDROBINEN   1   1 = rotating priority; 0 = fixed priority (port 0 highest)
// PORTS
//  clk           in   1                      clock, rising edge
//  async_rst     in   1                      asynchronous reset, active-high
//  clk_en        in   1                      global enable; all state frozen when low
//  ReqVector     in   PORTCOUNT              per-port request, level
//  ReqLock       in   PORTCOUNT              hold the current grant past credit expiry
//  PortWeights   in   PORTCOUNT*WEIGHTWIDTH  transfers per grant; port i = [i*W +: W]
//  GrantReady    in   1                      downstream accepts the current transfer
//  GrantValid    out  1                      a grant is active
//  GrantIndex    out  PORTADDRWIDTH          index of the granted port
//  GrantOneHot   out  PORTCOUNT              one-hot form of GrantIndex; zero when !GrantValid
// BEHAVIOUR
//  Reset (async, any time): GrantValid=0, GrantIndex=0, GrantOneHot=0, PriorityIndex=0,
//   Credit=0, state=IDLE. The effect is immediate and takes priority mid-grant.
//  clk_en=0: no state changes. Outputs hold their values. Transfers do not count.
//  Selection (combinational): the first set bit of the masked requests, scanned cyclically
//   from Base. Wrap goes PORTCOUNT-1 -> 0, never into unused codes >= PORTCOUNT.
//   Base = PriorityIndex if ROUNDROBINEN=1, else 0.
//  Transfer = GrantValid & GrantReady & clk_en.
//  Weight of 0 is treated as 1. Credit width = WEIGHTWIDTH.
//  States:
//   IDLE:  if any ReqVector bit is set, register the winner on the next edge:
//          GrantValid=1, GrantIndex=winner, Credit=weight(winner), state=GRANT.
//          Latency: request sampled at edge N gives GrantValid high after edge N.
//   GRANT: no transfer and ReqVector[GrantIndex]=1 -> hold all state (backpressure).
//          Transfer with ReqLock[GrantIndex]=1 -> keep the grant; Credit holds at its
//           current value, minimum 1.
//          Transfer, not locked, Credit>1 and request still set -> Credit-1, keep grant.
//          Release conditions:
//           - transfer, not locked, Credit==1;
//           - ReqVector[GrantIndex]==0, with or without a transfer (withdrawn request).
//          Release action: PriorityIndex = GrantIndex+1, wrapping at PORTCOUNT-1 to 0.
//           Re-arbitrate in the same cycle with Base = the new PriorityIndex over
//           ReqVector with bit GrantIndex masked. If there is a winner, load it on the
//           same edge (back-to-back grants, no bubble). Otherwise go to IDLE with
//           GrantValid=0.
//          If the released port is the only requester, it is re-granted after one IDLE cycle.
//  PortWeights and ReqLock are sampled only at grant load and at each transfer edge.
//  Changing PortWeights mid-grant does not alter the current Credit.
//  GrantIndex retains its last value in IDLE, but GrantOneHot is all zeros.
// TESTING
//  T1 PORTCOUNT=3, weights all 1, Req=3'b111, Ready=1 -> GrantIndex 0,1,2,0,1 on
//     consecutive cycles with no bubbles; index 3 never appears.
//  T2 W0=3, W1=1, Req=4'b0011, Ready=1 -> GrantIndex sequence 0,0,0,1,0,0,0,1.
//  T3 Grant on port 2 (W=2), Ready=0 for 5 cycles -> GrantIndex=2 and Credit=2 unchanged.
//     Then Ready=1 -> exactly two transfers before the grant moves to the next requester.
//  T4 Lock: ReqLock[1]=1 for 6 transfers with W1=1 and Req=4'b1111 -> grant stays on 1.
//     Drop the lock -> the next grant goes to port 2.
//  T5 ROUNDROBINEN=0, Req=4'b0110, weights 1 -> 1, then 2, then 1 ...
//     (release masks the current port, so the pointer does not rotate).
//     Req=4'b1111 after release of 1 -> the next grant goes to port 0.
//  T6 async_rst pulsed mid-GRANT between clock edges -> outputs go to 0 immediately.
//     After release with Req=4'b1000 -> the first grant is port 3 one cycle later.

Source files
------------

// File: rtl/weighted_rr_arbiter.sv
// Registered N-port weighted round-robin arbiter with grant lock and valid/ready handshake.
// Each grant is held for up to weight(port) accepted transfers, then priority rotates.

module wrrPortCell #(
    parameter int WEIGHTWIDTH = 4
) (
    input  logic                   req,
    input  logic                   masked,
    input  logic [WEIGHTWIDTH-1:0] rawWeight,
    output logic                   eligible,
    output logic [WEIGHTWIDTH-1:0] weight
);
    assign eligible = req & ~masked;
    // A zero weight would stall a grant with no credit, so it behaves as one transfer.
    assign weight   = (rawWeight == '0) ? WEIGHTWIDTH'(1) : rawWeight;
endmodule

module weighted_rr_arbiter #(
    parameter int PORTCOUNT     = 4,
    parameter int PORTADDRWIDTH = 2,
    parameter int WEIGHTWIDTH   = 4,
    parameter int ROUNDROBINEN  = 1
) (
    input  logic                             clk,
    input  logic                             async_rst,
    input  logic                             clk_en,
    input  logic [PORTCOUNT-1:0]             ReqVector,
    input  logic [PORTCOUNT-1:0]             ReqLock,
    input  logic [PORTCOUNT*WEIGHTWIDTH-1:0] PortWeights,
    input  logic                             GrantReady,
    output logic                             GrantValid,
    output logic [PORTADDRWIDTH-1:0]         GrantIndex,
    output logic [PORTCOUNT-1:0]             GrantOneHot
);
    localparam int AW = PORTADDRWIDTH;
    localparam int WW = WEIGHTWIDTH;

    typedef enum logic {IDLE, GRANT} state_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] index;
        logic [WW-1:0] credit;
        logic [AW-1:0] prio;
    } grantReg_t;

    state_t    state, stateNext;
    grantReg_t grantQ, grantD;

    logic [PORTCOUNT-1:0][WW-1:0] rawWeights;
    logic [PORTCOUNT-1:0][WW-1:0] effWeights;
    logic [PORTCOUNT-1:0]         selMask;
    logic [PORTCOUNT-1:0]         selReq;
    logic [PORTCOUNT-1:0]         curOneHot;
    logic [AW-1:0]                selBase;
    logic [AW-1:0]                selIdx;
    logic [AW-1:0]                wrapIndex;
    logic                         selFound;
    logic                         curReq;
    logic                         locked;
    logic                         transfer;
    logic                         releaseNow;
    logic                         loadNow;

    assign rawWeights = PortWeights;

    genvar gi;
    generate
        for (gi = 0; gi < PORTCOUNT; gi++) begin : gPort
            wrrPortCell #(.WEIGHTWIDTH(WW)) uCell (
                .req       (ReqVector[gi]),
                .masked    (selMask[gi]),
                .rawWeight (rawWeights[gi]),
                .eligible  (selReq[gi]),
                .weight    (effWeights[gi])
            );
        end
    endgenerate

    // Current-grant bookkeeping; clk_en gating lives in the register, so transfer ignores it here.
    always_comb begin
        curOneHot  = PORTCOUNT'(1) << grantQ.index;
        curReq     = ReqVector[grantQ.index];
        locked     = ReqLock[grantQ.index];
        transfer   = grantQ.valid & GrantReady;
        wrapIndex  = (grantQ.index == AW'(PORTCOUNT - 1)) ? '0 : grantQ.index + AW'(1);
        releaseNow = (state == GRANT) &&
                     (!curReq || (transfer && !locked && grantQ.credit <= WW'(1)));
    end

    // In GRANT the selector only matters on release: start after the released port and skip it.
    always_comb begin
        selMask = '0;
        selBase = '0;
        if (state == GRANT) begin
            selMask = curOneHot;
            if (ROUNDROBINEN != 0) selBase = wrapIndex;
        end else if (ROUNDROBINEN != 0) begin
            selBase = grantQ.prio;
        end
    end

    // Cyclic first-set scan from selBase; wraps at PORTCOUNT-1 so unused codes never appear.
    always_comb begin
        logic [AW:0] p;
        p        = '0;
        selFound = 1'b0;
        selIdx   = '0;
        for (int k = PORTCOUNT - 1; k >= 0; k--) begin
            p = {1'b0, selBase} + (AW+1)'(k);
            if (p >= (AW+1)'(PORTCOUNT)) p = p - (AW+1)'(PORTCOUNT);
            if (selReq[p[AW-1:0]]) begin
                selFound = 1'b1;
                selIdx   = p[AW-1:0];
            end
        end
    end

    always_comb begin
        stateNext = state;
        grantD    = grantQ;
        loadNow   = 1'b0;
        unique case (state)
            IDLE: loadNow = selFound;
            GRANT: begin
                if (releaseNow) begin
                    grantD.prio = wrapIndex;
                    if (selFound) begin
                        loadNow = 1'b1;
                    end else begin
                        stateNext    = IDLE;
                        grantD.valid = 1'b0;
                    end
                end else if (transfer) begin
                    if (locked)
                        grantD.credit = (grantQ.credit == '0) ? WW'(1) : grantQ.credit;
                    else
                        grantD.credit = grantQ.credit - WW'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
        if (loadNow) begin
            stateNext     = GRANT;
            grantD.valid  = 1'b1;
            grantD.index  = selIdx;
            grantD.credit = effWeights[selIdx];
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state  <= IDLE;
            grantQ <= '0;
        end else if (clk_en) begin
            state  <= stateNext;
            grantQ <= grantD;
        end
    end

    assign GrantValid  = grantQ.valid;
    assign GrantIndex  = grantQ.index;
    assign GrantOneHot = grantQ.valid ? curOneHot : '0;

endmodule
